axi4_lite_reg_slave: RTL
========================

// Module: axi4_lite_reg_slave
// PURPOSE
//  AXI4-Lite responder: NUM_REGS x 32-bit read/write register bank on the AW/W/B/AR/R channels.
//  Accepts AW and W independently, in either order, and returns B/R responses.
//  Register contents and per-register write strobes are exported to fabric logic.
//  Sits opposite AXI4_Lite_Master as the control-register endpoint of a peripheral.
// PARAMETERS
//  ADDR_W     4             byte-address width; register index = addr[ADDR_W-1:2]
//  DATA_W     32            data width (fixed 32; other values unsupported)
//  NUM_REGS   4             register count; must be <= 2**(ADDR_W-2)
//  RESET_VAL  32'h0000_0000 reset value of every register
// PORTS
//  ACLK      in   1                clock, rising edge
//  ARESETn   in   1                asynchronous active-low reset
//  AWADDR    in   ADDR_W           write address
//  AWVALID   in   1                write address valid
//  AWREADY   out  1                write address ready
//  WDATA     in   DATA_W           write data
//  WVALID    in   1                write data valid
//  WREADY    out  1                write data ready
//  BRESP     out  2                write response: 2'b00 OKAY, 2'b10 SLVERR
//  BVALID    out  1                write response valid
//  BREADY    in   1                write response ready
//  ARADDR    in   ADDR_W           read address
//  ARVALID   in   1                read address valid
//  ARREADY   out  1                read address ready
//  RDATA     out  DATA_W           read data
//  RRESP     out  2                read response, same encoding as BRESP
//  RVALID    out  1                read data valid
//  RREADY    in   1                read data ready
//  regs_o    out  NUM_REGS*DATA_W  register contents; reg i at [i*32 +: 32]
//  wr_pulse  out  NUM_REGS         1-cycle strobe, bit i high the cycle after reg i is written
// BEHAVIOUR
//  Reset (async assert, sync release): regs = RESET_VAL; BVALID, RVALID, wr_pulse = 0; BRESP, RRESP, RDATA = 0;
//   both FSMs go to IDLE. Reset mid-transaction drops all captured address/data with no response.
//  Write FSM: W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
//   AWREADY = state in {W_IDLE, W_HAVE_D}; WREADY = state in {W_IDLE, W_HAVE_A}.
//   IDLE: AW+W handshake in the same cycle -> commit -> W_RESP; AW only -> W_HAVE_A; W only -> W_HAVE_D.
//   HAVE_A: W handshake -> commit -> W_RESP. HAVE_D: AW handshake -> commit -> W_RESP.
//   Commit: register written on the edge closing the final handshake; BVALID and wr_pulse high the next cycle.
//   W_RESP: BVALID held with BRESP stable until BREADY; W_IDLE on the BVALID&BREADY edge. No AW/W accepted in W_RESP.
//  Read FSM: R_IDLE, R_DATA.
//   ARREADY = (state == R_IDLE). An AR handshake registers RDATA/RRESP from current contents -> R_DATA.
//   RVALID = 1 in R_DATA, held with RDATA stable until RREADY; then R_IDLE. Read latency is 1 cycle.
//  Index >= NUM_REGS: the write is dropped and BRESP = SLVERR; a read gives RDATA = 0 and RRESP = SLVERR.
//  Read and write to the same register with handshakes in one cycle: the read returns the pre-write value.
//  Read and write channels are fully independent and may be active at the same time.
//  VALID is never required before READY; the responder never waits on xREADY before asserting xVALID.
// CONFIGURATION
//  AXIL_SLV_ALIGN_CHK_EN defined: AWADDR[1:0] or ARADDR[1:0] != 0 -> SLVERR; the write is dropped and a read returns 0.
//  Undefined: addr[1:0] is ignored; misaligned accesses go to register addr[ADDR_W-1:2] with OKAY.
// TESTING
//  AW 0x4 and W 32'h2 in the same cycle, BREADY=1 -> BVALID next cycle, BRESP=00, regs_o[63:32]=2, wr_pulse=4'b0010 for 1 cycle.
//  W 32'hA5 three cycles before AW 0x8 -> WREADY low until AW is accepted; reg2=32'hA5 and only one B response.
//  Write 0x0..0xC = 1,2,3,4, then read each with RREADY=1 -> RDATA 1,2,3,4, RRESP=00, one cycle after each AR.
//  Hold BREADY=0 for 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0; the next write is accepted after BREADY.
//  Same-cycle AR 0x0 and AW/W 0x0 = 32'hFF with reg0=1 -> RDATA=1, then a later read returns 32'hFF.
//  Assert ARESETn low in W_HAVE_A -> no BVALID; all regs = RESET_VAL; with ALIGN_CHK_EN, read 0x6 -> RRESP=10, RDATA=0.

Source files
------------

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank responder: NUM_REGS x 32-bit registers with AW/W accepted in either order.
// Optional build macro AXIL_SLV_ALIGN_CHK_EN rejects accesses whose addr[1:0] is non-zero with SLVERR.
module axi4_lite_reg_slave #(
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 32,
    parameter int                NUM_REGS  = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic [ADDR_W-1:0]          AWADDR,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [DATA_W-1:0]          WDATA,
    input  logic                       WVALID,
    output logic                       WREADY,
    output logic [1:0]                 BRESP,
    output logic                       BVALID,
    input  logic                       BREADY,
    input  logic [ADDR_W-1:0]          ARADDR,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    output logic [DATA_W-1:0]          RDATA,
    output logic [1:0]                 RRESP,
    output logic                       RVALID,
    input  logic                       RREADY,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]        wr_pulse
);

    localparam int         IDX_W       = ADDR_W - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic              commit;
    logic              c_err;
    logic              rd_err;
    logic [DATA_W-1:0] rd_val;

    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        logic [1:0] unused_lsb;
        logic       idx_bad;
        unused_lsb = a[1:0];
        idx_bad    = (32'(a[ADDR_W-1:2]) >= 32'(NUM_REGS));
`ifdef AXIL_SLV_ALIGN_CHK_EN
        return idx_bad || (a[1:0] != 2'b00);
`else
        return idx_bad;
`endif
    endfunction

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // The commit source mux picks whichever half of the write was parked earlier.
    always_comb begin
        w_next  = w_state;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        commit  = 1'b0;
        c_addr  = AWADDR;
        c_data  = WDATA;
        case (w_state)
            W_IDLE: begin
                AWREADY = 1'b1;
                WREADY  = 1'b1;
                if (AWVALID && WVALID) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end else if (AWVALID) begin
                    w_next = W_HAVE_A;
                end else if (WVALID) begin
                    w_next = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                WREADY = 1'b1;
                c_addr = aw_addr_q;
                if (WVALID) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_HAVE_D: begin
                AWREADY = 1'b1;
                c_data  = w_data_q;
                if (AWVALID) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign c_err = addr_err(c_addr);

    always_ff @(posedge ACLK) begin
        if (AWVALID && AWREADY) aw_addr_q <= AWADDR;
        if (WVALID && WREADY)   w_data_q  <= WDATA;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
            wr_pulse <= '0;
            BRESP    <= RESP_OKAY;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                BRESP <= c_err ? RESP_SLVERR : RESP_OKAY;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (!c_err && (c_addr[ADDR_W-1:2] == IDX_W'(i))) begin
                        regs[i]     <= c_data;
                        wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_o[i*DATA_W +: DATA_W] = regs[i];
    end

    // Read path samples the bank before any same-edge write lands.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ARADDR[ADDR_W-1:2] == IDX_W'(i)) rd_val = regs[i];
        end
    end

    assign rd_err = addr_err(ARADDR);

    always_comb begin
        r_next  = r_state;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        case (r_state)
            R_IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) r_next = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            RDATA <= '0;
            RRESP <= RESP_OKAY;
        end else if ((r_state == R_IDLE) && ARVALID) begin
            RDATA <= rd_err ? '0 : rd_val;
            RRESP <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

endmodule
